// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared codes and types for the video SRAM arbiter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
//
// Holds owner codes, bus direction codes, arbiter FSM encodings, the
// read-tag record carried through the return pipe and default bus widths.
package vram_arbiter_pkg;

   // Default SRAM geometry (word address, data width).
   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 16;

   // Width of the host starvation counter; covers HOST_MAX_WAIT up to 255.
   localparam int STARVE_W = 8;

   // Owner of an issued read, used to route returning data.
   localparam logic OWN_DISP = 1'b0;
   localparam logic OWN_HOST = 1'b1;

   // Direction of the last command driven onto the SRAM data bus.
   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } dir_e;

   // Arbiter state: IDLE (nothing issued last cycle), ISSUE (a command was
   // granted last cycle), TURN (last cycle was a forced bus-turnaround slot).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      TURN  = 2'd2
   } arb_state_e;

   // One entry of the read-return tag pipe.
   typedef struct packed {
      logic vld;    // entry belongs to a real read
      logic owner;  // OWN_DISP or OWN_HOST
   } rd_tag_t;

   // Saturating increment used by the starvation counter.
   function automatic logic [STARVE_W-1:0] sat_inc(
      input logic [STARVE_W-1:0] v,
      input logic [STARVE_W-1:0] lim
   );
      return (v >= lim) ? lim : v + STARVE_W'(1);
   endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// vram_rd_tag_pipe: DEPTH-stage shift of {valid, owner} tags for SRAM reads.
// Latency: a tag pushed in cycle c appears on the output in cycle c+DEPTH.
// Backpressure: none; shifts every cycle, clr empties every stage.
//
// Ports:
//   clk        system clock
//   clr        synchronous clear (drops all in-flight tags)
//   push_vld   1 when the command presented this cycle is a read
//   push_owner owner of that read (OWN_DISP / OWN_HOST)
//   out_vld    oldest stage holds a read whose data is on mem_rdata now
//   out_owner  owner of that read
module vram_rd_tag_pipe
   import vram_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic push_vld,
   input  logic push_owner,
   output logic out_vld,
   output logic out_owner
);

   rd_tag_t [DEPTH-1:0] pipe;
   rd_tag_t             tag_in;

   assign tag_in.vld   = push_vld;
   assign tag_in.owner = push_owner;

   // Idle cycles and writes shift in vld=0, so the stage count alone
   // lines each read up with its data on mem_rdata.
   always_ff @(posedge clk) begin
      if (clr) begin
         pipe <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign out_vld   = pipe[DEPTH-1].vld;
   assign out_owner = pipe[DEPTH-1].owner;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video SRAM between display scan-out
//   reads and host reads/writes; display has priority, host starvation bounded.
// Latency: grant in cycle t -> command on mem_* in t+1 -> rvalid/rdata in t+1+RD_LAT.
// Backpressure: req is held until req && gnt; gnt drops during rst and during
//   the single idle slot inserted when the bus direction must change.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   disp_req/disp_addr/disp_gnt      display read request, address, grant
//   disp_rvalid/disp_rdata           display read return (one-cycle pulse)
//   host_req/host_we/host_addr/
//   host_wdata/host_gnt              host request (we=1 write), grant
//   host_rvalid/host_rdata           host read return (one-cycle pulse)
//   mem_cs/mem_we/mem_addr/mem_wdata registered SRAM command
//   mem_rdata                        SRAM read data, valid RD_LAT after command
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int RD_LAT        = 2,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   // display scan-out fetcher
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   // host bus bridge
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   // external SRAM
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Elaboration-time range checks on the parameters.
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("vram_arbiter: RD_LAT must be in 1..4");
   end
   if (HOST_MAX_WAIT < 1 || HOST_MAX_WAIT > 255) begin : g_bad_max_wait
      $error("vram_arbiter: HOST_MAX_WAIT must be in 1..255");
   end

   localparam logic [STARVE_W-1:0] MAX_WAIT = STARVE_W'(HOST_MAX_WAIT);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   arb_state_e          state_q;
   dir_e                last_dir_q;   // direction of the last issued command
   logic [STARVE_W-1:0] starve_q;     // consecutive cycles host was refused
   logic                cmd_owner_q;  // owner of the command now on mem_*

   // ------------------------------------------------------------------
   // Arbitration (combinational)
   // ------------------------------------------------------------------
   logic host_starved;
   logic cand_vld;
   logic cand_host;
   dir_e cand_dir;
   logic turn_need;
   logic grant_ok;

   // A starved host pre-empts display; otherwise display wins any tie.
   assign host_starved = host_req && (starve_q == MAX_WAIT);
   assign cand_vld     = disp_req || host_req;
   assign cand_host    = host_starved || (host_req && !disp_req);
   assign cand_dir     = (cand_host && host_we) ? DIR_WR : DIR_RD;

   // Opposite-direction commands need one empty bus slot between them.
   // In TURN that slot has just been spent, so any candidate may go, even
   // if the winner changed during the idle cycle.
   assign turn_need = cand_vld && (state_q != TURN) && (cand_dir != last_dir_q);

   assign grant_ok = !rst && cand_vld && !turn_need;
   assign disp_gnt = grant_ok && !cand_host;
   assign host_gnt = grant_ok && cand_host;

   // ------------------------------------------------------------------
   // FSM, counters and registered SRAM command
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_dir_q  <= DIR_RD;
         starve_q    <= '0;
         cmd_owner_q <= OWN_DISP;
         mem_cs      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         // Next state: a pending turnaround dominates; otherwise the state
         // just records whether a command went out this cycle.
         if (turn_need) begin
            state_q <= TURN;
         end else if (grant_ok) begin
            state_q <= ISSUE;
         end else begin
            state_q <= IDLE;
         end

         // Idle slots leave last_dir untouched, so a direction change after
         // a gap still costs one turnaround cycle.
         if (grant_ok) begin
            last_dir_q <= cand_dir;
         end

         if (!host_req || host_gnt) begin
            starve_q <= '0;
         end else begin
            starve_q <= sat_inc(starve_q, MAX_WAIT);
         end

         // Command register. Address/data hold when idle to limit pin toggling.
         mem_cs      <= grant_ok;
         mem_we      <= host_gnt && host_we;
         cmd_owner_q <= host_gnt ? OWN_HOST : OWN_DISP;
         if (disp_gnt) begin
            mem_addr <= disp_addr;
         end else if (host_gnt) begin
            mem_addr <= host_addr;
         end
         if (host_gnt && host_we) begin
            mem_wdata <= host_wdata;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read return routing
   // ------------------------------------------------------------------
   logic tag_vld;
   logic tag_owner;

   // Tags are pushed when the command is on the pins (t+1), so a pipe of
   // RD_LAT stages surfaces each tag exactly when its data is on mem_rdata.
   vram_rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .clr        (rst),
      .push_vld   (mem_cs && !mem_we),
      .push_owner (cmd_owner_q),
      .out_vld    (tag_vld),
      .out_owner  (tag_owner)
   );

   // Gated by rst as well so that, with RD_LAT=1, a tag already at the pipe
   // output cannot pulse while reset is asserted.
   assign disp_rvalid = !rst && tag_vld && (tag_owner == OWN_DISP);
   assign host_rvalid = !rst && tag_vld && (tag_owner == OWN_HOST);
   assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
   assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule
